// File: rtl/duckhunt_pkg.sv
// Shared duck-hunt constants plus the small bit helpers used by the shot scheduler.
package duckhunt_pkg;

  localparam int unsigned MAX_SHOT_SLOTS          = 8;
  localparam int unsigned SHOT_IDX_W              = 3;
  localparam int unsigned DEFAULT_LIFETIME_FRAMES = 30;
  localparam int unsigned DEFAULT_COOLDOWN_FRAMES = 4;

  function automatic logic [SHOT_IDX_W-1:0] lowest_set(input logic [MAX_SHOT_SLOTS-1:0] v);
    logic [SHOT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_SHOT_SLOTS - 1; i >= 0; i--) begin
      if (v[i]) idx = SHOT_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] popcount(input logic [MAX_SHOT_SLOTS-1:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_SHOT_SLOTS; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/shot_slot_timer.sv
// One shot slot: active flag plus a frame-based age countdown; kill beats ageing.
module shot_slot_timer #(
  parameter int unsigned LIFETIME_FRAMES = 30,
  parameter int unsigned AGE_W           = $clog2(LIFETIME_FRAMES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             kill,
  input  logic             frame_tick,
  output logic             active,
  output logic [AGE_W-1:0] age,
  output logic             active_nxt
);

  logic             active_d;
  logic [AGE_W-1:0] age_d;

  always_comb begin
    active_d = active;
    age_d    = age;
    if (active && kill) begin
      active_d = 1'b0;
      age_d    = '0;
    end else if (load) begin
      active_d = 1'b1;
      age_d    = AGE_W'(LIFETIME_FRAMES);
    end else if (active && frame_tick) begin
      if (age <= AGE_W'(1)) begin
        active_d = 1'b0;
        age_d    = '0;
      end else begin
        age_d = age - AGE_W'(1);
      end
    end
  end

  // Lets the parent register a population count that tracks the active flag exactly.
  assign active_nxt = ~reset & active_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      age    <= '0;
    end else begin
      active <= active_d;
      age    <= age_d;
    end
  end

endmodule

// File: rtl/shot_slot_scheduler.sv
// Claims the lowest free shot slot on each fire and ages slots per frame.
// Optional fire lockout after each accepted shot is enabled by defining SHOT_COOLDOWN_EN.
module shot_slot_scheduler
  import duckhunt_pkg::*;
#(
  parameter int unsigned NUM_SLOTS       = MAX_SHOT_SLOTS,
  parameter int unsigned LIFETIME_FRAMES = DEFAULT_LIFETIME_FRAMES,
  parameter int unsigned COOLDOWN_FRAMES = DEFAULT_COOLDOWN_FRAMES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fire,
  input  logic                  frame_tick,
  input  logic [NUM_SLOTS-1:0]  hit_clear,
  output logic [NUM_SLOTS-1:0]  slot_active,
  output logic                  fire_ack,
  output logic [SHOT_IDX_W-1:0] fire_slot,
  output logic                  fire_drop,
  output logic                  full,
  output logic [3:0]            active_count
);

  localparam int unsigned AGE_W = $clog2(LIFETIME_FRAMES + 1);

  logic [NUM_SLOTS-1:0]      load;
  logic [NUM_SLOTS-1:0]      active_nxt;
  logic [MAX_SHOT_SLOTS-1:0] free_pad;
  logic [MAX_SHOT_SLOTS-1:0] nxt_pad;
  logic [SHOT_IDX_W-1:0]     alloc_idx;
  logic                      cd_busy;
  logic                      accept;
  // Per-slot ages live inside the timers; this level only needs the active flags.
  logic [AGE_W-1:0]          unused_slot_age [NUM_SLOTS];

  always_comb begin
    free_pad                = '0;
    free_pad[NUM_SLOTS-1:0] = ~slot_active;
    nxt_pad                 = '0;
    nxt_pad[NUM_SLOTS-1:0]  = active_nxt;
    alloc_idx               = lowest_set(free_pad);
    accept                  = fire & (|free_pad) & ~cd_busy;
    load                    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      load[i] = accept && (alloc_idx == SHOT_IDX_W'(i));
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    shot_slot_timer #(
      .LIFETIME_FRAMES(LIFETIME_FRAMES),
      .AGE_W          (AGE_W)
    ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .load      (load[i]),
      .kill      (hit_clear[i]),
      .frame_tick(frame_tick),
      .active    (slot_active[i]),
      .age       (unused_slot_age[i]),
      .active_nxt(active_nxt[i])
    );
  end

`ifdef SHOT_COOLDOWN_EN
  localparam int unsigned CD_W = $clog2(COOLDOWN_FRAMES + 1);

  logic [CD_W-1:0] cd_q;

  assign cd_busy = (cd_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cd_q <= '0;
    end else if (accept) begin
      cd_q <= CD_W'(COOLDOWN_FRAMES);
    end else if (frame_tick && cd_busy) begin
      cd_q <= cd_q - CD_W'(1);
    end
  end
`else
  logic unused_cooldown_cfg;

  assign unused_cooldown_cfg = (COOLDOWN_FRAMES == 0);
  assign cd_busy             = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fire_ack     <= 1'b0;
      fire_drop    <= 1'b0;
      fire_slot    <= '0;
      active_count <= '0;
    end else begin
      fire_ack     <= accept;
      fire_drop    <= fire & ~accept;
      active_count <= popcount(nxt_pad);
      if (accept) fire_slot <= alloc_idx;
    end
  end

  assign full = &slot_active;

endmodule
